// File: rtl/vga_canvas_ctrl_if.sv
// Mouse/clear request bundle feeding the VGA canvas controller.
// Deltas and buttons are qualified by iMouseValid; iClear is a level request.
interface vga_canvas_ctrl_if;
    logic       iMouseValid;
    logic [8:0] iMouseDx;
    logic [8:0] iMouseDy;
    logic [2:0] iButtons;
    logic       iClear;

    modport master (output iMouseValid, iMouseDx, iMouseDy, iButtons, iClear);
    modport slave  (input  iMouseValid, iMouseDx, iMouseDy, iButtons, iClear);
endinterface

// File: rtl/vga_canvas_ctrl.sv
// VGA sync/colour generator with clamped mouse cursor and a one-bit canvas
// painted by a cross-shaped brush; canvas is exported flat on oImage.
module vga_canvas_ctrl #(
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 32,
    parameter int CELL_SHIFT = 4,
    parameter int CURSOR_W   = 8,
    parameter int CURSOR_H   = 16
) (
    input  logic                     clkVga,
    input  logic                     iRst,
    vga_canvas_ctrl_if.slave         mif,
    output logic [3:0]               oRed,
    output logic [3:0]               oGreen,
    output logic [3:0]               oBlue,
    output logic                     oHs,
    output logic                     oVs,
    output logic                     oBusy,
    output logic [10:0]              oCursorX,
    output logic [10:0]              oCursorY,
    output logic [GRID_W*GRID_H-1:0] oImage
);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);
    localparam logic [11:0] H_TOT = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [11:0] V_TOT = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [11:0] H_ST  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] V_ST  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] H_EN  = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_EN  = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] HS12  = 12'(H_SYNC);
    localparam logic [11:0] VS12  = 12'(V_SYNC);
    localparam logic [11:0] GW12  = 12'(GRID_W);
    localparam logic [11:0] GH12  = 12'(GRID_H);
    localparam logic [11:0] CW1   = 12'(CURSOR_W - 1);
    localparam logic [11:0] CH1   = 12'(CURSOR_H - 1);
    localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, STROKE, CLEAR} state_t;

    logic [11:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic [10:0]      x_q, x_d, y_q, y_d;
    logic [1:0]       btn_q, btn_d;
    logic [NCELL-1:0] image_q, image_d;
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [2:0]       step_q, step_d;
    logic [11:0]      ccx_q, ccx_d, ccy_q, ccy_d, row_q, row_d;
    logic             val_q, val_d;

    logic [11:0]        h_pos, v_pos, h_cell, v_cell, cur_cx, cur_cy, s_cx, s_cy;
    logic               active, in_cur, pix_set, cur_in, tgt;
    logic [IW-1:0]      pix_idx, cur_idx, s_idx, row_base;
    logic signed [11:0] dx_s, dy_s, nx, ny;
    logic               unused_btn;

    assign unused_btn = mif.iButtons[2];

    // Sync and colour are registered from the same counter values so they stay aligned.
    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_TOT - 12'd1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_TOT - 12'd1) ? '0 : v_cnt_q + 12'd1;
        end
        h_pos   = h_cnt_q - H_ST;
        v_pos   = v_cnt_q - V_ST;
        active  = (h_cnt_q >= H_ST) && (h_cnt_q < H_EN) && (v_cnt_q >= V_ST) && (v_cnt_q < V_EN);
        in_cur  = (h_pos >= {1'b0, x_q}) && (h_pos <= {1'b0, x_q} + CW1) &&
                  (v_pos >= {1'b0, y_q}) && (v_pos <= {1'b0, y_q} + CH1);
        h_cell  = h_pos >> CELL_SHIFT;
        v_cell  = v_pos >> CELL_SHIFT;
        pix_idx = IW'(v_cell * GRID_W + h_cell);
        pix_set = (h_cell < GW12) && (v_cell < GH12) && image_q[pix_idx];
        rgb_d   = 12'h000;
        if (active) begin
            if (in_cur)       rgb_d = btn_q[0] ? 12'h00F : (btn_q[1] ? 12'h0F0 : 12'hF00);
            else if (pix_set) rgb_d = 12'hF0F;
            else              rgb_d = 12'h888;
        end
        hs_d = (h_cnt_q >= HS12);
        vs_d = (v_cnt_q >= VS12);
    end

    always_comb begin
        dx_s  = {{3{mif.iMouseDx[8]}}, mif.iMouseDx};
        dy_s  = {{3{mif.iMouseDy[8]}}, mif.iMouseDy};
        nx    = $signed({1'b0, x_q}) + dx_s;
        ny    = $signed({1'b0, y_q}) - dy_s;
        x_d   = x_q;
        y_d   = y_q;
        btn_d = btn_q;
        if (mif.iMouseValid) begin
            if (nx < 12'sd0)       x_d = '0;
            else if (nx > X_MAX)   x_d = X_MAX[10:0];
            else                   x_d = nx[10:0];
            if (ny < 12'sd0)       y_d = '0;
            else if (ny > Y_MAX)   y_d = Y_MAX[10:0];
            else                   y_d = ny[10:0];
            btn_d = mif.iButtons[1:0];
        end
    end

    always_comb begin
        cur_cx   = {1'b0, x_q} >> CELL_SHIFT;
        cur_cy   = {1'b0, y_q} >> CELL_SHIFT;
        cur_in   = (cur_cx < GW12) && (cur_cy < GH12);
        cur_idx  = IW'(cur_cy * GRID_W + cur_cx);
        tgt      = btn_q[0];
        s_cx     = ccx_q;
        s_cy     = ccy_q;
        // Unsigned cell coords: cx-1 at column 0 wraps high and fails the grid test.
        case (step_q)
            3'd1:    s_cx = ccx_q + 12'd1;
            3'd2:    s_cx = ccx_q - 12'd1;
            3'd3:    s_cy = ccy_q + 12'd1;
            3'd4:    s_cy = ccy_q - 12'd1;
            default: ;
        endcase
        s_idx    = IW'(s_cy * GRID_W + s_cx);
        row_base = IW'(row_q * GRID_W);
        state_d  = state_q;
        image_d  = image_q;
        step_d   = step_q;
        ccx_d    = ccx_q;
        ccy_d    = ccy_q;
        val_d    = val_q;
        row_d    = row_q;
        case (state_q)
            IDLE: begin
                if (mif.iClear) begin
                    state_d = CLEAR;
                    row_d   = '0;
                end else if ((|btn_q) && cur_in && (image_q[cur_idx] != tgt)) begin
                    state_d = STROKE;
                    step_d  = '0;
                    ccx_d   = cur_cx;
                    ccy_d   = cur_cy;
                    val_d   = tgt;
                end
            end
            STROKE: begin
                if (mif.iClear) begin
                    state_d = CLEAR;
                    row_d   = '0;
                end else begin
                    if ((s_cx < GW12) && (s_cy < GH12)) image_d[s_idx] = val_q;
                    if (step_q == 3'd4) state_d = IDLE;
                    else                step_d  = step_q + 3'd1;
                end
            end
            CLEAR: begin
                image_d[row_base +: GRID_W] = '0;
                if (row_q == GH12 - 12'd1) state_d = IDLE;
                else                       row_d   = row_q + 12'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clkVga or posedge iRst) begin
        if (iRst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            btn_q   <= '0;
            image_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            step_q  <= '0;
            ccx_q   <= '0;
            ccy_q   <= '0;
            val_q   <= 1'b0;
            row_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            image_q <= image_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            ccx_q   <= ccx_d;
            ccy_q   <= ccy_d;
            val_q   <= val_d;
            row_q   <= row_d;
        end
    end

    assign oRed     = rgb_q[11:8];
    assign oGreen   = rgb_q[7:4];
    assign oBlue    = rgb_q[3:0];
    assign oHs      = hs_q;
    assign oVs      = vs_q;
    assign oBusy    = busy_q;
    assign oCursorX = x_q;
    assign oCursorY = y_q;
    assign oImage   = image_q;
endmodule

// File: tb/tb_vga_canvas_ctrl.sv
// Bench for vga_canvas_ctrl: shrunken video timing so a whole frame fits the
// cycle budget; canvas and cursor are checked against a cell-level model.
module tb_vga_canvas_ctrl;
    localparam int HS = 8, HBP = 8, HA = 240, HFP = 8, HT = HS + HBP + HA + HFP;
    localparam int VS = 2, VBP = 3, VA = 210, VFP = 1, VT = VS + VBP + VA + VFP;
    localparam int GW = 32, GH = 32, CS = 4;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] oRed, oGreen, oBlue;
    logic oHs, oVs, oBusy;
    logic [10:0] oCursorX, oCursorY;
    logic [GW*GH-1:0] oImage;

    vga_canvas_ctrl_if mif();

    vga_canvas_ctrl #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS), .CURSOR_W(8), .CURSOR_H(16)
    ) dut (
        .clkVga(clk), .iRst(rst), .mif(mif),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oHs(oHs), .oVs(oVs),
        .oBusy(oBusy), .oCursorX(oCursorX), .oCursorY(oCursorY), .oImage(oImage)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk, n_pass;
    int mx, my;
    logic [1:0] mbtn;
    bit mimg [GH][GW];

    typedef struct { int dx; int dy; int ex; int ey; } cur_vec_t;
    cur_vec_t vt [14];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void m_reset();
        mx = 0; my = 0; mbtn = 2'b00;
        for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) mimg[y][x] = 1'b0;
    endfunction

    function automatic void m_paint(input int cx, input int cy, input bit t);
        if (cx >= 0 && cx < GW && cy >= 0 && cy < GH) mimg[cy][cx] = t;
    endfunction

    // Cursor moves then, if a button is held and the centre differs, a cross is painted.
    function automatic void m_strobe(input int dx, input int dy, input int b);
        int cx, cy;
        bit t;
        mx = clampi(mx + dx, 0, HA - 1);
        my = clampi(my - dy, 0, VA - 1);
        mbtn = 2'(b);
        cx = mx / 16;
        cy = my / 16;
        t = mbtn[0];
        if (mbtn != 2'b00 && cx < GW && cy < GH && mimg[cy][cx] != t) begin
            m_paint(cx, cy, t); m_paint(cx + 1, cy, t); m_paint(cx - 1, cy, t);
            m_paint(cx, cy + 1, t); m_paint(cx, cy - 1, t);
        end
    endfunction

    function automatic int img_diff();
        int d = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (oImage[y*GW + x] !== mimg[y][x]) d++;
        return d;
    endfunction

    task automatic strobe(input int dx, input int dy, input int b);
        @(negedge clk);
        mif.iMouseValid = 1'b1;
        mif.iMouseDx = 9'(dx);
        mif.iMouseDy = 9'(dy);
        mif.iButtons = 3'(b);
        @(negedge clk);
        mif.iMouseValid = 1'b0;
        m_strobe(dx, dy, b);
    endtask

    task automatic settle(output int bc);
        bc = 0;
        @(negedge clk);
        for (int i = 0; i < 100 && oBusy; i++) begin
            bc++;
            @(negedge clk);
        end
        if (oBusy) check("settle_timeout", 1, 0);
    endtask

    task automatic move_to(input int x, input int y, input int b, output int bc);
        int t;
        strobe(-256, 255, 0);
        settle(t);
        strobe(x, -y, b);
        settle(bc);
    endtask

    // Free-run with cursor at (0,0), no buttons, empty canvas; sample k holds counter value k.
    task automatic run_sync(input int n, input string tag, input bit full);
        int e_hs, e_vs, e_col, hs_low0, vs_low, nz_line, nz_tot, h, v;
        logic [11:0] ecol, col;
        e_hs = 0; e_vs = 0; e_col = 0; hs_low0 = 0; vs_low = 0; nz_line = 0; nz_tot = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            h = k % HT;
            v = (k / HT) % VT;
            col = {oRed, oGreen, oBlue};
            ecol = 12'h000;
            if (h >= HS + HBP && h < HS + HBP + HA && v >= VS + VBP && v < VS + VBP + VA)
                ecol = (h - HS - HBP < 8 && v - VS - VBP < 16) ? 12'hF00 : 12'h888;
            if (oHs !== (h >= HS)) e_hs++;
            if (oVs !== (v >= VS)) e_vs++;
            if (col !== ecol) e_col++;
            if (k < HT && oHs == 1'b0) hs_low0++;
            if (oVs == 1'b0) vs_low++;
            if (v == VS + VBP + 20 && col != 12'h000) nz_line++;
            if (col != 12'h000) nz_tot++;
        end
        check({tag, "_hs_mismatch"}, e_hs, 0);
        check({tag, "_vs_mismatch"}, e_vs, 0);
        check({tag, "_colour_mismatch"}, e_col, 0);
        check({tag, "_hs_low_line0"}, hs_low0, HS);
        if (full) begin
            check({tag, "_vs_low_cycles"}, vs_low, VS * HT);
            check({tag, "_active_per_line"}, nz_line, HA);
            check({tag, "_active_total"}, nz_tot, HA * VA);
        end
    endtask

    initial begin
        int bc;
        n_chk = 0; n_pass = 0;
        mif.iMouseValid = 1'b0; mif.iMouseDx = '0; mif.iMouseDy = '0;
        mif.iButtons = '0; mif.iClear = 1'b0;
        rst = 1'b1;
        m_reset();
        vt[0]  = '{-5, 0, 0, 0};
        for (int i = 1; i <= 8; i++) vt[i] = '{100, 0, (i == 1) ? 100 : ((i == 2) ? 200 : HA - 1), 0};
        vt[9]  = '{0, -50, HA - 1, 50};
        vt[10] = '{0, 10, HA - 1, 40};
        vt[11] = '{0, 100, HA - 1, 0};
        vt[12] = '{0, -255, HA - 1, VA - 1};
        vt[13] = '{-256, 0, 0, VA - 1};

        repeat (3) @(negedge clk);
        check("rst_hs", oHs, 0);
        check("rst_vs", oVs, 0);
        check("rst_rgb", {oRed, oGreen, oBlue}, 0);
        check("rst_busy", oBusy, 0);
        check("rst_x", oCursorX, 0);
        check("rst_y", oCursorY, 0);
        check("rst_image_ones", $countones(oImage), 0);
        rst = 1'b0;
        run_sync(HT * VT, "frame", 1'b1);

        foreach (vt[i]) begin
            strobe(vt[i].dx, vt[i].dy, 0);
            check($sformatf("cur_x_%0d", i), oCursorX, vt[i].ex);
            check($sformatf("cur_y_%0d", i), oCursorY, vt[i].ey);
            settle(bc);
        end

        move_to(0, 0, 1, bc);
        check("d_busy", bc, 5);
        check("d_bit0", oImage[0], 1);
        check("d_bit1", oImage[1], 1);
        check("d_bit32", oImage[32], 1);
        check("d_bit31", oImage[31], 0);
        check("d_bit992", oImage[992], 0);
        check("d_img", img_diff(), 0);

        move_to(200, 200, 1, bc);
        check("e_draw_busy", bc, 5);
        check("e_bit396_set", oImage[396], 1);
        strobe(0, 0, 2);
        settle(bc);
        check("e_erase_busy", bc, 5);
        check("e_bits_cleared", oImage[396] | oImage[395] | oImage[397] | oImage[364] | oImage[428], 0);
        check("e_img", img_diff(), 0);
        strobe(0, 0, 2);
        settle(bc);
        check("e_noop_busy", bc, 0);

        move_to(100, 100, 0, bc);
        strobe(0, 0, 1);
        @(negedge clk);
        check("f_stroke_busy", oBusy, 1);
        @(negedge clk);
        mif.iClear = 1'b1;
        mif.iMouseValid = 1'b1; mif.iMouseDx = '0; mif.iMouseDy = '0; mif.iButtons = '0;
        @(negedge clk);
        mif.iClear = 1'b0;
        mif.iMouseValid = 1'b0;
        m_strobe(0, 0, 0);
        for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) mimg[y][x] = 1'b0;
        bc = 0;
        for (int i = 0; i < 100 && oBusy; i++) begin
            bc++;
            @(negedge clk);
        end
        check("f_clear_busy", bc, GH);
        repeat (4) @(negedge clk);
        check("f_idle_after", oBusy, 0);
        check("f_image_ones", $countones(oImage), 0);

        for (int i = 0; i < 40; i++) begin
            int dx, dy, b;
            dx = int'($urandom_range(0, 120)) - 60;
            dy = int'($urandom_range(0, 120)) - 60;
            b  = int'($urandom_range(0, 3));
            strobe(dx, dy, b);
            settle(bc);
            check($sformatf("rnd_x_%0d", i), oCursorX, mx);
            check($sformatf("rnd_y_%0d", i), oCursorY, my);
            check($sformatf("rnd_img_%0d", i), img_diff(), 0);
        end

        move_to(200, 200, 1, bc);
        strobe(0, 0, 0);
        settle(bc);
        check("g_img_before", img_diff(), 0);
        @(negedge clk);
        mif.iClear = 1'b1;
        @(negedge clk);
        mif.iClear = 1'b0;
        repeat (3) @(negedge clk);
        check("g_in_clear", oBusy, 1);
        rst = 1'b1;
        #1;
        check("g_busy", oBusy, 0);
        check("g_image_ones", $countones(oImage), 0);
        check("g_x", oCursorX, 0);
        check("g_y", oCursorY, 0);
        check("g_hs", oHs, 0);
        check("g_vs", oVs, 0);
        check("g_rgb", {oRed, oGreen, oBlue}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        run_sync(2 * HT, "rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
